// File: rtl/prbs_checker_if.sv
// Bus bundle between a PRBS checker and its receive-side client.
// Carries serial input, count-clear control and status/error outputs.
interface prbs_checker_if #(
  parameter int CNT_W = 16
) ();
  logic             din_valid;
  logic             din;
  logic             clr_count;
  logic             locked;
  logic             PRBS_error;
  logic [CNT_W-1:0] err_count;

  modport master (
    output din_valid, din, clr_count,
    input  locked, PRBS_error, err_count
  );

  modport slave (
    input  din_valid, din, clr_count,
    output locked, PRBS_error, err_count
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with windowed loss-of-lock and saturating error count.
// Optional macro PRBS_INVERT_EN: invert din before any use (inverted PRBS streams).
module prbs_checker #(
  parameter int POLY_LEN    = 7,
  parameter int TAP_B       = 6,
  parameter int LOCK_CNT    = 16,
  parameter int WINDOW      = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          reset,
  prbs_checker_if.slave bus
);

  localparam int SCW = $clog2(POLY_LEN + LOCK_CNT + 1);
  localparam int WBW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WEW = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {SEED, SYNC, LOCKED} state_t;

  state_t              state, state_nxt;
  logic [POLY_LEN-1:0] sr, sr_nxt;
  logic [SCW-1:0]      cnt, cnt_nxt;
  logic [WBW-1:0]      win_bit, win_bit_nxt;
  logic [WEW-1:0]      win_err, win_err_nxt, win_err_inc;
  logic [CNT_W-1:0]    err_count, err_count_nxt;
  logic                locked_p1;
  logic                err_p0, err_p1;
  logic                d, e, mis;

`ifdef PRBS_INVERT_EN
  assign d = ~bus.din;
`else
  assign d = bus.din;
`endif

  assign e   = sr[POLY_LEN-1] ^ sr[TAP_B-1];
  assign mis = d ^ e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    cnt_nxt       = cnt;
    win_bit_nxt   = win_bit;
    win_err_nxt   = win_err;
    err_count_nxt = err_count;
    err_p0        = 1'b0;
    win_err_inc   = win_err + WEW'(mis);
    if (bus.din_valid) begin
      case (state)
        SEED: begin
          sr_nxt = {sr[POLY_LEN-2:0], d};
          if (cnt == SCW'(POLY_LEN - 1)) begin
            state_nxt = SYNC;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        SYNC: begin
          sr_nxt = {sr[POLY_LEN-2:0], d};
          if (mis) begin
            state_nxt = SEED;
            cnt_nxt   = '0;
          end else if (cnt == SCW'(LOCK_CNT - 1)) begin
            state_nxt   = LOCKED;
            cnt_nxt     = '0;
            win_bit_nxt = '0;
            win_err_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        LOCKED: begin
          // Regenerate from the local LFSR so a corrupted bit never enters sr
          sr_nxt = {sr[POLY_LEN-2:0], e};
          err_p0 = mis;
          if (mis) err_count_nxt = sat_inc(err_count);
          if (win_err_inc == WEW'(UNLOCK_ERRS)) begin
            state_nxt   = SEED;
            cnt_nxt     = '0;
            win_bit_nxt = '0;
            win_err_nxt = '0;
          end else if (win_bit == WBW'(WINDOW - 1)) begin
            win_bit_nxt = '0;
            win_err_nxt = '0;
          end else begin
            win_bit_nxt = win_bit + 1'b1;
            win_err_nxt = win_err_inc;
          end
        end
        default: state_nxt = SEED;
      endcase
    end
    if (bus.clr_count) err_count_nxt = '0;
  end

  // p1: registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEED;
      sr        <= '0;
      cnt       <= '0;
      win_bit   <= '0;
      win_err   <= '0;
      err_count <= '0;
      locked_p1 <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      cnt       <= cnt_nxt;
      win_bit   <= win_bit_nxt;
      win_err   <= win_err_nxt;
      err_count <= err_count_nxt;
      locked_p1 <= (state_nxt == LOCKED);
      err_p1    <= err_p0;
    end
  end

  assign bus.locked     = locked_p1;
  assign bus.PRBS_error = err_p1;
  assign bus.err_count  = err_count;

endmodule
